alu_rr_scheduler: RTL and testbench



---
 rtl/alu_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/alu_rr_scheduler.sv | 168 ++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes, FSM state
// encoding and the requester-id width helper.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index granted most recently; search starts just after it
//   grant      - one-hot grant (zero when no request)
//   grant_idx  - index of the granted requester
//   any_req    - at least one request is present
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_req
);

  // Cyclic search from last_grant+1; the first hit wins.
  always_comb begin
    int unsigned j;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    j         = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      j = 32'(last_grant) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any_req && req[j[ID_W-1:0]]) begin
        any_req             = 1'b1;
        grant[j[ID_W-1:0]]  = 1'b1;
        grant_idx           = j[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered add/sub/mul ALU between N_REQ requesters with
// round-robin arbitration and a single id-tagged response channel.
// Optional macro ALU_SCHED_STATS_EN adds saturating op_count / err_count.
// Ports:
//   clk, rstn                  - clock, asynchronous active-low reset
//   req_valid/req_ready        - per-requester request handshake
//   req_a/req_b/req_op         - packed per-requester operands and opcode
//   alu_a/alu_b/alu_ctrl       - drive to the shared ALU (ctrl never 2'b11)
//   alu_res                    - registered ALU result
//   rsp_valid/rsp_ready        - response handshake
//   rsp_id/rsp_res/rsp_err     - response payload
//   op_count/err_count         - completion counters (ALU_SCHED_STATS_EN only)
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int unsigned PART_LEN = 8,
  parameter  int unsigned N_REQ    = 4,
  localparam int unsigned W        = 2 * PART_LEN,
  localparam int unsigned ID_W     = id_width(N_REQ)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [2*N_REQ-1:0] req_op,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic [1:0]         alu_ctrl,
  input  logic [W-1:0]       alu_res,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [W-1:0]       rsp_res,
  output logic               rsp_err
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]        op_count,
  output logic [7:0]         err_count
`endif
);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              any_req;
  logic [W-1:0]      op_a, op_b;
  logic [1:0]        op_code;
  logic [ID_W-1:0]   op_id;
  logic [W-1:0]      sel_a, sel_b;
  logic [1:0]        sel_op;
  logic              accept;
  logic              rsp_hs;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  // Operand mux for the granted requester.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = OP_ADD;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*W +: W];
        sel_b  = req_b[i*W +: W];
        sel_op = req_op[2*i +: 2];
      end
    end
  end

  assign accept = (state == S_IDLE) && any_req;
  assign rsp_hs = (state == S_RESP) && rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = (sel_op == OP_RSV) ? S_RESP : S_EXEC;
      S_EXEC:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; ALU inputs only live during EXEC/WAIT.
  always_comb begin
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = OP_ADD;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: req_ready = grant;
      S_EXEC, S_WAIT: begin
        alu_a    = op_a;
        alu_b    = op_b;
        // Reserved ops never reach EXEC; the guard keeps 2'b11 off the bus.
        alu_ctrl = (op_code == OP_RSV) ? OP_ADD : op_code;
      end
      S_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, response payload and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= OP_ADD;
      op_id      <= '0;
      rsp_id     <= '0;
      rsp_res    <= '0;
      rsp_err    <= 1'b0;
      last_grant <= ID_W'(N_REQ - 1);
    end else begin
      if (accept) begin
        op_a    <= sel_a;
        op_b    <= sel_b;
        op_code <= sel_op;
        op_id   <= grant_idx;
        if (sel_op == OP_RSV) begin
          rsp_id  <= grant_idx;
          rsp_res <= '0;
          rsp_err <= 1'b1;
        end
      end
      if (state == S_WAIT) begin
        rsp_id  <= op_id;
        rsp_res <= alu_res;
        rsp_err <= 1'b0;
      end
      if (rsp_hs) last_grant <= op_id;
    end
  end

`ifdef ALU_SCHED_STATS_EN
  // Saturating completion counters, split by error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (rsp_hs) begin
      if (rsp_err) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else begin
        if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;

  localparam int PART_LEN = 8;
  localparam int N_REQ    = 4;
  localparam int W        = 16;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a = '0;
  logic [N_REQ*W-1:0] req_b = '0;
  logic [2*N_REQ-1:0] req_op = '0;
  logic [W-1:0]       alu_a, alu_b;
  logic [1:0]         alu_ctrl;
  logic [W-1:0]       alu_res = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [1:0]         rsp_id;
  logic [W-1:0]       rsp_res;
  logic               rsp_err;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0]        op_count;
  logic [7:0]         err_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit seen_ctrl11 = 1'b0;

  alu_rr_scheduler #(.PART_LEN(PART_LEN), .N_REQ(N_REQ)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_err(rsp_err)
`ifdef ALU_SCHED_STATS_EN
    , .op_count(op_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference registered ALU: add/sub/mul truncated to W, 2'b11 clears.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    case (alu_ctrl)
      2'b00:   alu_res <= alu_a + alu_b;
      2'b01:   alu_res <= alu_a - alu_b;
      2'b10:   alu_res <= W'(alu_a * alu_b);
      default: alu_res <= '0;
    endcase
  end

  always @(negedge clk) if (alu_ctrl == 2'b11) seen_ctrl11 = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for rsp_valid; timeout counts as a failure.
  task automatic wait_rsp(output bit ok);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    ok = rsp_valid;
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    req_a[v.id*W +: W] = v.a;
    req_b[v.id*W +: W] = v.b;
    req_op[v.id*2 +: 2] = v.op;
    req_valid = 4'(1 << v.id);
    #1;
    chk("vec_req_ready", 32'(req_ready), 32'(1 << v.id));
    tick();
    req_valid = '0;
    if (v.err) begin
      chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("err_ctrl_idle", 32'(alu_ctrl), 32'd0);
    end else begin
      chk("exec_ctrl", 32'(alu_ctrl), 32'(v.op));
      chk("exec_alu_a", 32'(alu_a), 32'(v.a));
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      chk("wait_ctrl", 32'(alu_ctrl), 32'(v.op));
      tick();
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
    end
    chk("rsp_id", 32'(rsp_id), 32'(v.id));
    chk("rsp_res", 32'(rsp_res), 32'(v.res));
    chk("rsp_err", 32'(rsp_err), 32'(v.err));
    chk("resp_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("idle_after_rsp", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    int last_cyc;
    logic [1:0]  hold_id;
    logic [15:0] hold_res;

    vecs[0] = '{0, 16'h0012, 16'h0034, 2'b00, 16'h0046, 1'b0};
    vecs[1] = '{2, 16'd10,   16'd3,    2'b01, 16'd7,    1'b0};
    vecs[2] = '{2, 16'h0102, 16'h0003, 2'b10, 16'h0306, 1'b0};
    vecs[3] = '{1, 16'h1234, 16'h5678, 2'b11, 16'h0000, 1'b1};
    vecs[4] = '{3, 16'h0005, 16'h0007, 2'b01, 16'hFFFE, 1'b0};
    vecs[5] = '{0, 16'h8000, 16'h0004, 2'b10, 16'h0000, 1'b0};
    vecs[6] = '{1, 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b0};

    // Reset state
    tick(); tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_res", 32'(rsp_res), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rstn = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);
`ifdef ALU_SCHED_STATS_EN
    chk("op_count", 32'(op_count), 32'd6);
    chk("err_count", 32'(err_count), 32'd1);
`endif

    // Fairness: all valid, rsp_ready held high
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*W +: W] = 16'(i);
      req_b[i*W +: W] = 16'd100;
      req_op[i*2 +: 2] = 2'b00;
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    last_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      wait_rsp(ok);
      chk("fair_id", 32'(rsp_id), 32'(k % 4));
      chk("fair_res", 32'(rsp_res), 32'(100 + (k % 4)));
      if (k > 0) chk("fair_spacing", 32'(cyc - last_cyc), 32'd4);
      last_cyc = cyc;
      tick();
    end

    // Backpressure: next grant is requester 2
    rsp_ready = 1'b0;
    wait_rsp(ok);
    hold_id  = rsp_id;
    hold_res = rsp_res;
    chk("bp_id", 32'(hold_id), 32'd2);
    chk("bp_res", 32'(hold_res), 32'd102);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id_hold", 32'(rsp_id), 32'(hold_id));
      chk("bp_res_hold", 32'(rsp_res), 32'(hold_res));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_ctrl", 32'(alu_ctrl), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_next_grant", 32'(req_ready), 32'b1000);
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();

    // Reset mid-operation during WAIT
    req_a[1*W +: W] = 16'd1;
    req_b[1*W +: W] = 16'd2;
    req_op[1*2 +: 2] = 2'b00;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    chk("mid_in_wait_ctrl", 32'(alu_ctrl), 32'd0);
    chk("mid_in_wait_a", 32'(alu_a), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    req_valid = 4'b1001;
    tick();
    rstn = 1'b1;
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    wait_rsp(ok);
    chk("mid_rsp_id", 32'(rsp_id), 32'd0);
    chk("mid_rsp_res", 32'(rsp_res), 32'd100);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`ifdef ALU_SCHED_STATS_EN
    chk("op_count_after_rst", 32'(op_count), 32'd1);
    chk("err_count_after_rst", 32'(err_count), 32'd0);
`endif

    chk("ctrl_never_11", 32'(seen_ctrl11), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
